// File: rtl/xgmii_measure_rx.sv
// -----------------------------------------------------------------------------
// xgmii_measure_rx
//
// Receive-side measurement engine for one 10GbE port. Parses 64-bit XGMII
// words, qualifies IPv4/UDP test frames (ethertype, IP protocol, magic
// signature, minimum length, no /E/), computes one-way latency from the
// 32-bit stamp carried in frame bytes 46..49, and publishes per-second
// frame and byte counts.
//
// Ports:
//   sys_clk          156.25 MHz XGMII clock (only clock)
//   sys_rst          asynchronous, active-high reset
//   sec_oneshot      one-cycle pulse once per second; closes the window
//   global_counter   free-running cycle counter shared with the TX generator
//   xgmii_rxd        XGMII data, lane 0 = [7:0] = first byte on the wire
//   xgmii_rxc        XGMII control, one bit per lane
//   rx_pps           qualified frames in the last closed window
//   rx_throughput    qualified bytes (dst MAC..FCS) in the last closed window
//   rx_latency       latency of the latest qualified frame, saturating
//   rx_ipv4_ip       IPv4 source address of the latest qualified frame
//   rx_latency_valid one-cycle strobe when rx_latency/rx_ipv4_ip update
// -----------------------------------------------------------------------------
module xgmii_measure_rx #(
  parameter logic [31:0] MAGIC_CODE = 32'hA5A5_5A5A,
  parameter logic [15:0] ETHERTYPE  = 16'h0800,
  parameter logic [7:0]  IP_PROTO   = 8'h11
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        sec_oneshot,
  input  logic [31:0] global_counter,
  input  logic [63:0] xgmii_rxd,
  input  logic [7:0]  xgmii_rxc,
  output logic [31:0] rx_pps,
  output logic [31:0] rx_throughput,
  output logic [23:0] rx_latency,
  output logic [31:0] rx_ipv4_ip,
  output logic        rx_latency_valid
);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_BODY, S_ERR} state_t;

  state_t      state, state_nxt;

  logic [15:0] data_words;   // data words received since the start word
  logic        eth_ok, proto_ok, magic_ok;
  logic [31:0] ip_cap;
  logic [15:0] stamp_hi;     // stamp bytes 46..47, held until word 7
  logic [23:0] lat_cap;
  logic [31:0] pps_acc, byte_acc;

  // Word decode
  logic        start_w, term_w, err_w;
  logic [2:0]  term_lane;

  // NOTE: every signal written in an always_comb gets a default at the top,
  // so no path can leave it unassigned and infer a latch.
  always_comb begin
    logic found;
    found     = 1'b0;
    term_w    = 1'b0;
    term_lane = 3'd0;
    err_w     = 1'b0;
    start_w   = (xgmii_rxc == 8'h01) && (xgmii_rxd[7:0] == 8'hFB);
    for (int i = 0; i < 8; i++) begin
      // Terminate is defined by the lowest control lane only.
      if (xgmii_rxc[i] && !found) begin
        found     = 1'b1;
        term_lane = 3'(i);
        term_w    = (xgmii_rxd[8*i +: 8] == 8'hFD);
      end
      if (xgmii_rxc[i] && (xgmii_rxd[8*i +: 8] == 8'hFE))
        err_w = 1'b1;
    end
  end

  logic        in_frame;
  logic [18:0] frame_bytes;
  logic        qualify;
  logic [31:0] lat_diff;

  assign in_frame    = (state == S_HDR) || (state == S_BODY);
  assign frame_bytes = {data_words, 3'b000} + 19'(term_lane);
  assign qualify     = in_frame && term_w && !err_w && eth_ok && proto_ok &&
                       magic_ok && (frame_bytes >= 19'd56);
  // Bytes 48..49 arrive in lanes 0..1 of word 7, so the stamp is completed
  // combinationally in the capture cycle.
  assign lat_diff    = global_counter -
                       {stamp_hi, xgmii_rxd[7:0], xgmii_rxd[15:8]};

  // State register
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next state: a start word wins over everything, then terminate, then /E/.
  always_comb begin
    state_nxt = state;
    if (start_w)
      state_nxt = S_HDR;
    else if (term_w)
      state_nxt = S_IDLE;
    else if (err_w)
      state_nxt = S_ERR;
    else if ((state == S_HDR) && (data_words == 16'd6))
      state_nxt = S_BODY;   // word 7 is the last header word
  end

  // Header extraction, latency capture and result registers
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      data_words       <= '0;
      eth_ok           <= 1'b0;
      proto_ok         <= 1'b0;
      magic_ok         <= 1'b0;
      ip_cap           <= '0;
      stamp_hi         <= '0;
      lat_cap          <= '0;
      pps_acc          <= '0;
      byte_acc         <= '0;
      rx_pps           <= '0;
      rx_throughput    <= '0;
      rx_latency       <= '0;
      rx_ipv4_ip       <= '0;
      rx_latency_valid <= 1'b0;
    end else begin
      rx_latency_valid <= 1'b0;

      if (start_w) begin
        data_words <= '0;
        eth_ok     <= 1'b0;
        proto_ok   <= 1'b0;
        magic_ok   <= 1'b0;
      end else if (in_frame && !term_w && !err_w) begin
        if (data_words != 16'hFFFF)
          data_words <= data_words + 16'd1;
        // data_words = word index - 1 for the word currently present
        case (data_words)
          16'd1: eth_ok   <= ({xgmii_rxd[39:32], xgmii_rxd[47:40]} == ETHERTYPE);
          16'd2: proto_ok <= (xgmii_rxd[63:56] == IP_PROTO);
          16'd3: ip_cap   <= {xgmii_rxd[23:16], xgmii_rxd[31:24],
                              xgmii_rxd[39:32], xgmii_rxd[47:40]};
          16'd5: begin
            magic_ok <= ({xgmii_rxd[23:16], xgmii_rxd[31:24],
                          xgmii_rxd[39:32], xgmii_rxd[47:40]} == MAGIC_CODE);
            stamp_hi <= {xgmii_rxd[55:48], xgmii_rxd[63:56]};
          end
          16'd6: lat_cap  <= (|lat_diff[31:24]) ? 24'hFF_FFFF : lat_diff[23:0];
          default: ;
        endcase
      end

      if (qualify) begin
        rx_latency       <= lat_cap;
        rx_ipv4_ip       <= ip_cap;
        rx_latency_valid <= 1'b1;
      end

      // A frame terminating with the window pulse lands in the published value.
      if (sec_oneshot) begin
        rx_pps        <= pps_acc  + (qualify ? 32'd1 : 32'd0);
        rx_throughput <= byte_acc + (qualify ? 32'(frame_bytes) : 32'd0);
        pps_acc       <= '0;
        byte_acc      <= '0;
      end else if (qualify) begin
        pps_acc       <= pps_acc  + 32'd1;
        byte_acc      <= byte_acc + 32'(frame_bytes);
      end
    end
  end

endmodule

// File: tb/tb_xgmii_measure_rx.sv
// -----------------------------------------------------------------------------
// tb_xgmii_measure_rx
//
// Directed bench for xgmii_measure_rx: single frame, latency wrap and
// saturation, minimum length, rejections, a 1000-frame burst, terminate
// coincident with the window pulse, asynchronous reset and start restart.
// Inputs change on the falling edge; outputs are read on the falling edge.
// -----------------------------------------------------------------------------
module tb_xgmii_measure_rx;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        sec_oneshot;
  logic [31:0] global_counter;
  logic [63:0] xgmii_rxd;
  logic [7:0]  xgmii_rxc;
  logic [31:0] rx_pps;
  logic [31:0] rx_throughput;
  logic [23:0] rx_latency;
  logic [31:0] rx_ipv4_ip;
  logic        rx_latency_valid;

  xgmii_measure_rx dut (
    .sys_clk          (sys_clk),
    .sys_rst          (sys_rst),
    .sec_oneshot      (sec_oneshot),
    .global_counter   (global_counter),
    .xgmii_rxd        (xgmii_rxd),
    .xgmii_rxc        (xgmii_rxc),
    .rx_pps           (rx_pps),
    .rx_throughput    (rx_throughput),
    .rx_latency       (rx_latency),
    .rx_ipv4_ip       (rx_ipv4_ip),
    .rx_latency_valid (rx_latency_valid)
  );

  always #5 sys_clk = ~sys_clk;

  localparam logic [63:0] IDLE_W  = {8{8'h07}};
  localparam logic [63:0] START_W = {8'hD5, {6{8'h55}}, 8'hFB};
  localparam logic [31:0] MAGIC   = 32'hA5A5_5A5A;

  int vectors     = 0;
  int miscompares = 0;
  int strobes     = 0;
  int s0;

  logic [7:0] fb [0:63];

  // Count latency strobes shortly after each rising edge.
  always @(posedge sys_clk) begin
    #1;
    if (rx_latency_valid === 1'b1) strobes++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one word at a falling edge and advance to the next falling edge.
  task automatic step(input logic [63:0] d, input logic [7:0] c);
    xgmii_rxd = d;
    xgmii_rxc = c;
    @(negedge sys_clk);
  endtask

  task automatic pulse_sec();
    sec_oneshot = 1'b1;
    step(IDLE_W, 8'hFF);
    sec_oneshot = 1'b0;
  endtask

  task automatic build(input logic [15:0] et, input logic [7:0] pr,
                       input logic [31:0] ip, input logic [31:0] mg,
                       input logic [31:0] st);
    for (int i = 0; i < 64; i++) fb[i] = 8'(i);
    fb[12] = et[15:8];  fb[13] = et[7:0];
    fb[23] = pr;
    fb[26] = ip[31:24]; fb[27] = ip[23:16]; fb[28] = ip[15:8]; fb[29] = ip[7:0];
    fb[42] = mg[31:24]; fb[43] = mg[23:16]; fb[44] = mg[15:8]; fb[45] = mg[7:0];
    fb[46] = st[31:24]; fb[47] = st[23:16]; fb[48] = st[15:8]; fb[49] = st[7:0];
  endtask

  function automatic logic [63:0] word_at(input int k);
    logic [63:0] w;
    for (int l = 0; l < 8; l++) w[8*l +: 8] = fb[8*(k-1) + l];
    return w;
  endfunction

  // Start word, nwords data words, terminate word with /T/ in lane tlane.
  task automatic send_frame(input int nwords, input int tlane,
                            input logic [31:0] gc7, input int err_word,
                            input logic sec_at_term);
    logic [63:0] w;
    step(START_W, 8'h01);
    for (int k = 1; k <= nwords; k++) begin
      if (k == 7) global_counter = gc7;
      if (k == err_word) step({56'h0, 8'hFE}, 8'h01);
      else               step(word_at(k), 8'h00);
    end
    w = IDLE_W;
    for (int l = 0; l < tlane; l++) w[8*l +: 8] = fb[8*nwords + l];
    w[8*tlane +: 8] = 8'hFD;
    sec_oneshot = sec_at_term;
    step(w, 8'(8'hFF << tlane));
    sec_oneshot = 1'b0;
  endtask

  initial begin
    sys_rst        = 1'b1;
    sec_oneshot    = 1'b0;
    global_counter = 32'h0;
    xgmii_rxd      = IDLE_W;
    xgmii_rxc      = 8'hFF;
    @(negedge sys_clk);
    @(negedge sys_clk);
    check("rst_pps",   rx_pps,           32'h0);
    check("rst_thr",   rx_throughput,    32'h0);
    check("rst_lat",   rx_latency,       32'h0);
    check("rst_ip",    rx_ipv4_ip,       32'h0);
    check("rst_valid", rx_latency_valid, 32'h0);
    sys_rst = 1'b0;
    step(IDLE_W, 8'hFF);

    // Single qualified 64-byte frame
    build(16'h0800, 8'h11, 32'hC0A8_0101, MAGIC, 32'h0000_1000);
    send_frame(8, 0, 32'h0000_1064, 0, 1'b0);
    check("single_valid", rx_latency_valid, 32'h1);
    check("single_lat",   rx_latency,       32'h64);
    check("single_ip",    rx_ipv4_ip,       32'hC0A8_0101);
    step(IDLE_W, 8'hFF);
    check("single_valid_drop", rx_latency_valid, 32'h0);
    pulse_sec();
    check("single_pps", rx_pps,        32'd1);
    check("single_thr", rx_throughput, 32'd64);

    // Counter wrap, saturation, and the 56-byte minimum
    build(16'h0800, 8'h11, 32'h0A00_0001, MAGIC, 32'hFFFF_FFF0);
    send_frame(8, 0, 32'h0000_0010, 0, 1'b0);
    check("wrap_lat", rx_latency, 32'h20);
    step(IDLE_W, 8'hFF);
    build(16'h0800, 8'h11, 32'h0A00_0002, MAGIC, 32'h0);
    send_frame(8, 0, 32'h0100_0000, 0, 1'b0);
    check("sat_lat", rx_latency, 32'hFF_FFFF);
    step(IDLE_W, 8'hFF);
    build(16'h0800, 8'h11, 32'h0A00_0003, MAGIC, 32'h0000_0100);
    send_frame(7, 0, 32'h0000_0180, 0, 1'b0);
    check("min56_valid", rx_latency_valid, 32'h1);
    check("min56_lat",   rx_latency,       32'h80);
    check("min56_ip",    rx_ipv4_ip,       32'h0A00_0003);
    step(IDLE_W, 8'hFF);
    pulse_sec();
    check("win2_pps", rx_pps,        32'd3);
    check("win2_thr", rx_throughput, 32'd184);

    // Rejections: bad magic, IPv6 ethertype, /E/ in word 4, 55-byte frame
    s0 = strobes;
    build(16'h0800, 8'h11, 32'h0B00_0001, 32'hA5A5_5A5B, 32'h0);
    send_frame(8, 0, 32'h5, 0, 1'b0);
    step(IDLE_W, 8'hFF);
    build(16'h86DD, 8'h11, 32'h0B00_0002, MAGIC, 32'h0);
    send_frame(8, 0, 32'h5, 0, 1'b0);
    step(IDLE_W, 8'hFF);
    build(16'h0800, 8'h11, 32'h0B00_0003, MAGIC, 32'h0);
    send_frame(8, 0, 32'h5, 4, 1'b0);
    step(IDLE_W, 8'hFF);
    build(16'h0800, 8'h11, 32'h0B00_0004, MAGIC, 32'h0);
    send_frame(6, 7, 32'h5, 0, 1'b0);
    step(IDLE_W, 8'hFF);
    check("rej_strobes", 32'(strobes), 32'(s0));
    check("rej_lat",     rx_latency,   32'h80);
    check("rej_ip",      rx_ipv4_ip,   32'h0A00_0003);
    pulse_sec();
    check("rej_pps", rx_pps,        32'd0);
    check("rej_thr", rx_throughput, 32'd0);

    // Line-rate burst, one idle word between frames
    build(16'h0800, 8'h11, 32'h0C00_0001, MAGIC, 32'h0);
    for (int n = 0; n < 1000; n++) begin
      send_frame(8, 0, 32'h10, 0, 1'b0);
      step(IDLE_W, 8'hFF);
    end
    check("burst_lat", rx_latency, 32'h10);
    pulse_sec();
    check("burst_pps", rx_pps,        32'd1000);
    check("burst_thr", rx_throughput, 32'd64000);
    pulse_sec();
    check("burst_next_pps", rx_pps,        32'd0);
    check("burst_next_thr", rx_throughput, 32'd0);

    // Terminate coincident with the window pulse
    build(16'h0800, 8'h11, 32'h0D00_0001, MAGIC, 32'h0);
    send_frame(8, 0, 32'h7, 0, 1'b0);
    step(IDLE_W, 8'hFF);
    send_frame(8, 0, 32'h7, 0, 1'b1);
    check("coin_valid", rx_latency_valid, 32'h1);
    check("coin_pps",   rx_pps,           32'd2);
    check("coin_thr",   rx_throughput,    32'd128);
    step(IDLE_W, 8'hFF);
    pulse_sec();
    check("coin_next_pps", rx_pps,        32'd0);
    check("coin_next_thr", rx_throughput, 32'd0);
    send_frame(8, 0, 32'h7, 0, 1'b0);
    step(IDLE_W, 8'hFF);
    pulse_sec();
    check("pre_rst_pps", rx_pps, 32'd1);

    // Asynchronous reset at word 5 of a frame
    build(16'h0800, 8'h11, 32'h0E00_0001, MAGIC, 32'h0);
    step(START_W, 8'h01);
    for (int k = 1; k <= 4; k++) step(word_at(k), 8'h00);
    xgmii_rxd = word_at(5);
    xgmii_rxc = 8'h00;
    #2 sys_rst = 1'b1;
    #1;
    check("arst_pps",   rx_pps,           32'h0);
    check("arst_thr",   rx_throughput,    32'h0);
    check("arst_lat",   rx_latency,       32'h0);
    check("arst_ip",    rx_ipv4_ip,       32'h0);
    check("arst_valid", rx_latency_valid, 32'h0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    s0 = strobes;
    step(word_at(6), 8'h00);
    global_counter = 32'h9;
    step(word_at(7), 8'h00);
    step(word_at(8), 8'h00);
    step({{7{8'h07}}, 8'hFD}, 8'hFF);
    step(IDLE_W, 8'hFF);
    check("arst_tail_strobes", 32'(strobes), 32'(s0));

    // A new start word mid-frame aborts the first frame
    build(16'h0800, 8'h11, 32'h0F00_0001, MAGIC, 32'h0000_0500);
    step(START_W, 8'h01);
    for (int k = 1; k <= 4; k++) step(word_at(k), 8'h00);
    send_frame(8, 0, 32'h0000_0600, 0, 1'b0);
    check("restart_valid", rx_latency_valid, 32'h1);
    check("restart_lat",   rx_latency,       32'h100);
    check("restart_ip",    rx_ipv4_ip,       32'h0F00_0001);
    step(IDLE_W, 8'hFF);
    pulse_sec();
    check("restart_pps", rx_pps,        32'd1);
    check("restart_thr", rx_throughput, 32'd64);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/xgmii_measure_rx.md
# xgmii_measure_rx

Receive-side measurement engine for one 10GbE port. It parses XGMII frames arriving on `xgmii_rxd`/`xgmii_rxc` and qualifies the IPv4/UDP test frames produced by the port-0 generator. For each qualifying frame it computes one-way latency from the embedded 32-bit `global_counter` stamp. Once per second it publishes packets-per-second and bytes-per-second to the PCI register block.

## Interface
Parameters:
- `MAGIC_CODE`, default 32'hA5A5_5A5A: 4-byte signature expected at frame bytes 42..45 (big-endian).
- `ETHERTYPE`, default 16'h0800: required value at bytes 12..13.
- `IP_PROTO`, default 8'h11: required value at byte 23.

Ports:
- `sys_clk` input 1: 156.25 MHz XGMII clock. The block has exactly one clock.
- `sys_rst` input 1: asynchronous, active-high reset.
- `sec_oneshot` input 1: one-cycle pulse, once per second.
- `global_counter` input 32: free-running cycle counter, shared with the TX generator.
- `xgmii_rxd` input 64: XGMII data. Lane 0 = bits [7:0] = first byte on the wire.
- `xgmii_rxc` input 8: XGMII control, one bit per lane.
- `rx_pps` output 32: frames qualified in the last closed one-second window.
- `rx_throughput` output 32: bytes, from dst MAC through FCS, of qualified frames in the last window.
- `rx_latency` output 24: latency in cycles of the most recent qualified frame; saturating.
- `rx_ipv4_ip` output 32: IPv4 source address of the most recent qualified frame.
- `rx_latency_valid` output 1: one-cycle strobe, asserted when `rx_latency` and `rx_ipv4_ip` update.

## Operation
- Frame byte 0 is the first dst-MAC byte, i.e. the first byte after the SFD.
- Start detection:
  - Requires `xgmii_rxc==8'h01` and `xgmii_rxd[7:0]==8'hFB`.
  - Preamble bytes are not checked.
  - A start in lane 4 is ignored.
- FSM states:
  - IDLE: on a start word → HDR, word index 1.
  - HDR: word index 1..7 (frame bytes 0..55). Extracts the following fields:
    - ethertype: bytes 12..13
    - protocol: byte 23
    - source IP: bytes 26..29
    - magic: bytes 42..45
    - stamp: bytes 46..49
  - BODY: data beyond byte 55.
  - Any state: a word whose lowest set `xgmii_rxc` lane carries 8'hFD is the terminate word → evaluate, then → IDLE.
  - Any state: any lane carrying 8'hFE (/E/) → ERR.
  - ERR: waits for the terminate word, then → IDLE. Nothing is counted.
  - Any state: a new start word restarts HDR. The aborted frame is dropped.
- Byte count: 8·(data words after the start word) + lane index of /T/ within the terminate word.
- Qualification, all required:
  - ethertype == `ETHERTYPE`
  - protocol == `IP_PROTO`
  - magic == `MAGIC_CODE`
  - byte count ≥ 56
  - no /E/ seen
- FCS is not checked.
- Latency:
  - Captured in the cycle that word index 7 is present: `global_counter − stamp`, 32-bit modular.
  - Results ≥ 2^24 saturate to 24'hFFFFFF.
  - Committed only if the frame qualifies.
- Window counters:
  - `pps_acc` and `byte_acc` are 32-bit and increment on each qualified terminate.
  - On `sec_oneshot`, the accumulators are copied to `rx_pps` and `rx_throughput`, then cleared.

## Timing
- All outputs are registered. All reset to 0, and the FSM resets to IDLE.
- Reset asserted mid-frame: the partial frame is discarded. After release, parsing resumes only at the next start word.
- `rx_latency`, `rx_ipv4_ip` and `rx_latency_valid` update one cycle after the terminate word is sampled.
- `rx_pps` and `rx_throughput` update one cycle after `sec_oneshot`.
- Terminate and `sec_oneshot` in the same cycle: the frame is included in the published window value, and the accumulators restart at 0.
- Back-to-back frames are supported:
  - A start word may arrive the cycle after a terminate word.
  - Terminate followed by a start in the same word (lane-4 start) is not supported; that start is ignored.
- Accumulators wrap modulo 2^32. This is not reachable within one second at line rate.

## Test plan
- **Single frame:** send one 64-byte qualified frame (8 data words, /T/ in lane 0 of the 9th word) with stamp 32'h0000_1000. Drive `global_counter` to 32'h0000_1064 at word 7. Expect:
  - `rx_latency`=24'h000064 and `rx_latency_valid` pulse 1 cycle after /T/
  - `rx_ipv4_ip` = the source IP in the frame
  - after `sec_oneshot`: `rx_pps`=1, `rx_throughput`=64
- **Counter wrap and saturation:**
  - stamp 32'hFFFF_FFF0 with counter 32'h0000_0010 → `rx_latency`=24'h000020
  - stamp 0 with counter 32'h0100_0000 → `rx_latency`=24'hFFFFFF
- **Rejection:** send 3 frames, one each with a wrong magic, ethertype 16'h86DD, or an /E/ in word 4. Expect no `rx_latency_valid` strobe, and `rx_pps`=0 / `rx_throughput`=0 after the next `sec_oneshot`.
- **Line-rate burst:** send 1000 back-to-back 64-byte frames with a 1-word IPG, then `sec_oneshot`. Expect `rx_pps`=1000 and `rx_throughput`=64000; the next window reads 0.
- **Terminate coincident with `sec_oneshot`:** the frame is counted in the published window, and the following window starts at 0.
- **Async reset and restart:**
  - Assert `sys_rst` at word 5 of a frame: all outputs read 0 immediately.
  - A new start word mid-frame aborts the first frame; only the second frame is counted.
